uart_tx: RTL and testbench

- Serial UART transmitter: accepts a parallel byte on a start strobe and shifts it out on a single line.
- Frame format: start bit, data LSB first, optional parity, stop bit(s).
- Sits between a byte-producing host (e.g. FIFO or controller) and the TX pad.
- Reports busy while sending and a one-cycle done pulse at frame end.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_if.sv | 20 ++
 rtl/uart_baud_tick.sv | 28 ++
 rtl/uart_tx.sv | 119 +++++++++++
 tb/tb_uart_tx.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter slice.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Rounded to the nearest whole clock so the baud error stays minimal.
  function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Host-side handshake of the UART transmitter: byte request in, status and line out.
interface uart_tx_if;

  logic       i_tx_start;
  logic [7:0] i_tx_byte;
  logic       o_tx_busy;
  logic       o_tx_done;
  logic       o_tx_serial_data;

  modport master (
    output i_tx_start, i_tx_byte,
    input  o_tx_busy, o_tx_done, o_tx_serial_data
  );

  modport slave (
    input  i_tx_start, i_tx_byte,
    output o_tx_busy, o_tx_done, o_tx_serial_data
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: one-cycle tick every CLKS_PER_BIT clocks, restartable on frame start.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_restart,
  output logic o_tick
);

  localparam int                CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_restart || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data LSB first, optional parity, STOP_BITS stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = calc_clks_per_bit(100_000_000, 115_200),
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1
) (
  input logic      i_clk,
  input logic      i_rst_n,
  uart_tx_if.slave bus
);

  localparam logic [7:0] DATA_MASK = 8'((1 << DATA_BITS) - 1);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  uart_state_t r_state;
  logic [7:0]  r_shift;
  logic [2:0]  r_bit_idx;
  logic        r_stop_idx;
  logic        r_parity;
  logic        r_serial;
  logic        r_busy;
  logic        r_done;

  logic        w_restart;
  logic        w_tick;
  logic [7:0]  w_data;

  assign w_data    = bus.i_tx_byte & DATA_MASK;
  assign w_restart = (r_state == ST_IDLE) && bus.i_tx_start;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_restart(w_restart),
    .o_tick   (w_tick)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= '0;
      r_parity   <= '0;
      r_serial   <= '1;
      r_busy     <= '0;
      r_done     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.i_tx_start) begin
            r_shift    <= w_data;
            r_parity   <= (PARITY == PAR_ODD) ? ~^w_data : ^w_data;
            r_bit_idx  <= '0;
            r_stop_idx <= '0;
            r_serial   <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_START;
          end
        end
        ST_START: begin
          if (w_tick) begin
            r_serial <= r_shift[0];
            r_shift  <= {1'b0, r_shift[7:1]};
            r_state  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            if (r_bit_idx == LAST_BIT) begin
              if (PARITY != PAR_NONE) begin
                r_serial <= r_parity;
                r_state  <= ST_PARITY;
              end else begin
                r_serial <= 1'b1;
                r_state  <= ST_STOP;
              end
            end else begin
              r_serial  <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (w_tick) begin
            r_serial <= 1'b1;
            r_state  <= ST_STOP;
          end
        end
        ST_STOP: begin
          // Line is already high; only the stop-bit count decides when to finish.
          if (w_tick) begin
            if (r_stop_idx == LAST_STOP) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_stop_idx <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_tx_serial_data = r_serial;
  assign bus.o_tx_busy        = r_busy;
  assign bus.o_tx_done        = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx across 8N1, 8E2, 8O1 (4 clk/bit) and the default 868 clk/bit build.
module tb_uart_tx;

  logic       clk;
  logic       rst_n;
  logic [3:0] start_v;
  logic [7:0] tx_byte;
  logic [2:0] obs_a [4];

  int vectors;
  int miscompares;
  int sel;
  int cur_cpb;
  bit mon_en;
  int frames_seen;

  logic exp_q[$];
  int   len_q[$];

  uart_tx_if if0 ();
  uart_tx_if if1 ();
  uart_tx_if if2 ();
  uart_tx_if if3 ();

  assign if0.i_tx_start = start_v[0];
  assign if1.i_tx_start = start_v[1];
  assign if2.i_tx_start = start_v[2];
  assign if3.i_tx_start = start_v[3];
  assign if0.i_tx_byte  = tx_byte;
  assign if1.i_tx_byte  = tx_byte;
  assign if2.i_tx_byte  = tx_byte;
  assign if3.i_tx_byte  = tx_byte;

  assign obs_a[0] = {if0.o_tx_serial_data, if0.o_tx_busy, if0.o_tx_done};
  assign obs_a[1] = {if1.o_tx_serial_data, if1.o_tx_busy, if1.o_tx_done};
  assign obs_a[2] = {if2.o_tx_serial_data, if2.o_tx_busy, if2.o_tx_done};
  assign obs_a[3] = {if3.o_tx_serial_data, if3.o_tx_busy, if3.o_tx_done};

  uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    d0 (.i_clk(clk), .i_rst_n(rst_n), .bus(if0));
  uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2))
    d1 (.i_clk(clk), .i_rst_n(rst_n), .bus(if1));
  uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1))
    d2 (.i_clk(clk), .i_rst_n(rst_n), .bus(if2));
  uart_tx d3 (.i_clk(clk), .i_rst_n(rst_n), .bus(if3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected line bit sequence of one frame, as seen on the wire.
  task automatic push_frame(input logic [7:0] b, input int par, input int stopb);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
    if (par == 1) exp_q.push_back(~^b);
    if (par == 2) exp_q.push_back(^b);
    for (int i = 0; i < stopb; i++) exp_q.push_back(1'b1);
    len_q.push_back(9 + ((par != 0) ? 1 : 0) + stopb);
  endtask

  // Scoreboard monitor: pops one expected bit per bit period and checks every cycle of it.
  initial begin : monitor
    bit       in_frame;
    bit       bad;
    int       c;
    int       nb;
    logic     expb;
    logic [2:0] o;
    logic [2:0] got;
    in_frame = 0;
    c = 0;
    nb = 0;
    bad = 0;
    expb = 1'b0;
    got = '0;
    forever begin
      @(posedge clk);
      #1;
      o = obs_a[sel];
      if (!mon_en) begin
        in_frame = 0;
      end else begin
        if (!in_frame) begin
          vectors++;
          if (o[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_done: got done=%b outside a frame, required 0", o[0]);
          end
          if (o[1] === 1'b1 && o[2] === 1'b0) begin
            vectors++;
            if (len_q.size() == 0) begin
              miscompares++;
              $display("FAIL unexpected_frame: got frame start at %0t, required none", $time);
            end else begin
              nb = len_q.pop_front();
              in_frame = 1;
              c = 0;
            end
          end
        end
        if (in_frame) begin
          if (c == nb * cur_cpb) begin
            vectors++;
            if (o !== 3'b101) begin
              miscompares++;
              $display("FAIL frame_end: got ser/busy/done=%b, required 101", o);
            end
            frames_seen++;
            in_frame = 0;
          end else begin
            if (c % cur_cpb == 0) begin
              expb = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
              bad = 0;
              got = o;
            end
            if (!bad && o !== {expb, 2'b10}) begin
              bad = 1;
              got = o;
            end
            if (c % cur_cpb == cur_cpb - 1) begin
              vectors++;
              if (bad) begin
                miscompares++;
                $display("FAIL line_bit%0d: got ser/busy/done=%b, required %b10",
                         c / cur_cpb, got, expb);
              end
            end
            c++;
          end
        end
      end
    end
  end

  task automatic test_reset();
    bit ok;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (obs_a[k] !== 3'b100) begin
        miscompares++;
        $display("FAIL reset_state%0d: got %b, required 100", k, obs_a[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    tx_byte = 8'hD4;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    vectors++;
    if (obs_a[0] !== 3'b010) begin
      miscompares++;
      $display("FAIL reset_pre_start: got %b, required 010", obs_a[0]);
    end
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (obs_a[0] !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_midframe: got %b, required 100", obs_a[0]);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ok = 1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (obs_a[0] !== 3'b100) ok = 0;
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL reset_release_idle: got %b, required 100", obs_a[0]);
    end
  endtask

  task automatic test_single_frame();
    int busy_n, done_n, done_at, f0;
    busy_n = 0; done_n = 0; done_at = -1;
    sel = 0; cur_cpb = 4; f0 = frames_seen;
    push_frame(8'hD4, 0, 1);
    @(negedge clk);
    tx_byte = 8'hD4;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (obs_a[0][1] === 1'b1) busy_n++;
      if (obs_a[0][0] === 1'b1) begin done_n++; done_at = i; end
    end
    vectors++;
    if (busy_n != 40) begin miscompares++; $display("FAIL single_busy: got %0d cycles, required 40", busy_n); end
    vectors++;
    if (done_n != 1) begin miscompares++; $display("FAIL single_done_cnt: got %0d, required 1", done_n); end
    vectors++;
    if (done_at != 40) begin miscompares++; $display("FAIL single_done_at: got %0d, required 40", done_at); end
    vectors++;
    if (frames_seen - f0 != 1 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL single_scoreboard: got %0d frames, %0d bits left, required 1, 0", frames_seen - f0, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int done_at[$];
    int f0;
    sel = 0; cur_cpb = 4; f0 = frames_seen;
    for (int n = 0; n < 3; n++) push_frame(8'hD4, 0, 1);
    @(negedge clk);
    tx_byte = 8'hD4;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 131; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (obs_a[0][0] === 1'b1) done_at.push_back(i);
      if (i == 82) start_v[0] = 1'b0;
    end
    vectors++;
    if (done_at.size() != 3) begin
      miscompares++;
      $display("FAIL b2b_done_cnt: got %0d, required 3", done_at.size());
    end else begin
      for (int n = 0; n < 3; n++) begin
        vectors++;
        if (done_at[n] != 40 + 41 * n) begin
          miscompares++;
          $display("FAIL b2b_done_at%0d: got %0d, required %0d", n, done_at[n], 40 + 41 * n);
        end
      end
    end
    vectors++;
    if (frames_seen - f0 != 3 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_scoreboard: got %0d frames, %0d bits left, required 3, 0", frames_seen - f0, exp_q.size());
    end
  endtask

  task automatic test_byte_change();
    int f0;
    sel = 0; cur_cpb = 4; f0 = frames_seen;
    push_frame(8'hD4, 0, 1);
    push_frame(8'h05, 0, 1);
    @(negedge clk);
    tx_byte = 8'hD4;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 91; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (i == 20) tx_byte = 8'h05;
      if (i == 41) start_v[0] = 1'b0;
    end
    vectors++;
    if (frames_seen - f0 != 2 || exp_q.size() != 0 || len_q.size() != 0) begin
      miscompares++;
      $display("FAIL bytechg_scoreboard: got %0d frames, %0d bits left, required 2, 0", frames_seen - f0, exp_q.size());
    end
  endtask

  task automatic test_parity_stop();
    int cfg_k[2]   = '{1, 2};
    int cfg_par[2] = '{2, 1};
    int cfg_stp[2] = '{2, 1};
    int cfg_len[2] = '{48, 44};
    for (int t = 0; t < 2; t++) begin
      int done_at, f0;
      done_at = -1;
      sel = cfg_k[t]; cur_cpb = 4; f0 = frames_seen;
      push_frame(8'h05, cfg_par[t], cfg_stp[t]);
      @(negedge clk);
      tx_byte = 8'h05;
      start_v[cfg_k[t]] = 1'b1;
      @(posedge clk);
      #1;
      start_v[cfg_k[t]] = 1'b0;
      for (int i = 0; i < 56; i++) begin
        if (i > 0) begin @(posedge clk); #1; end
        if (obs_a[cfg_k[t]][0] === 1'b1 && done_at < 0) done_at = i;
      end
      vectors++;
      if (done_at != cfg_len[t]) begin
        miscompares++;
        $display("FAIL parity_len_p%0d: got %0d, required %0d", cfg_par[t], done_at, cfg_len[t]);
      end
      vectors++;
      if (frames_seen - f0 != 1 || exp_q.size() != 0) begin
        miscompares++;
        $display("FAIL parity_scoreboard_p%0d: got %0d frames, %0d bits left, required 1, 0", cfg_par[t], frames_seen - f0, exp_q.size());
      end
    end
  endtask

  task automatic test_default_baud();
    longint t0, t_rise, t_done;
    int done_at, f0;
    logic prev;
    t_rise = -1; t_done = -1; done_at = -1;
    sel = 3; cur_cpb = 868; f0 = frames_seen;
    push_frame(8'hD4, 0, 1);
    @(negedge clk);
    tx_byte = 8'hD4;
    start_v[3] = 1'b1;
    @(posedge clk);
    #1;
    start_v[3] = 1'b0;
    t0 = $time;
    prev = obs_a[3][2];
    for (int i = 0; i < 8700; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (t_rise < 0 && prev === 1'b0 && obs_a[3][2] === 1'b1) t_rise = $time;
      prev = obs_a[3][2];
      if (done_at < 0 && obs_a[3][0] === 1'b1) begin done_at = i; t_done = $time; end
    end
    vectors++;
    if (done_at != 8680) begin miscompares++; $display("FAIL baud_done_at: got %0d, required 8680", done_at); end
    vectors++;
    if (t_done - t0 != 86800) begin miscompares++; $display("FAIL baud_frame_ns: got %0d, required 86800", t_done - t0); end
    vectors++;
    if (t_rise - t0 != 26040) begin miscompares++; $display("FAIL baud_first_rise_ns: got %0d, required 26040", t_rise - t0); end
    vectors++;
    if (frames_seen - f0 != 1 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL baud_scoreboard: got %0d frames, %0d bits left, required 1, 0", frames_seen - f0, exp_q.size());
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    frames_seen = 0;
    sel = 0;
    cur_cpb = 4;
    mon_en = 0;
    rst_n = 1'b0;
    start_v = '0;
    tx_byte = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    exp_q.delete();
    len_q.delete();
    repeat (2) @(posedge clk);
    mon_en = 1;
    test_single_frame();
    test_back_to_back();
    test_byte_change();
    test_parity_stop();
    test_default_baud();
    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
